// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes and scan state encoding for the seg7 driver
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Active-high codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-high seven-segment code
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with double-buffered display data
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int GUARD_CYCLES   = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [2:0]              scan_idx,
  output logic                    frame_done
);

  localparam int               CNT_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

  // scan_clk is data here: synchronize, retime once more, then detect the rise
  logic r_sync_meta, r_sync, r_sync_d, r_sync_prev, r_tick;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_sync_d    <= 1'b0;
      r_sync_prev <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_sync_meta <= scan_clk;
      r_sync      <= r_sync_meta;
      r_sync_d    <= r_sync;
      r_sync_prev <= r_sync_d;
      r_tick      <= r_sync_d & ~r_sync_prev;
    end
  end

  scan_state_t      r_state, w_nxt_state;
  logic [2:0]       r_idx, w_nxt_idx;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             w_wrap, w_frame_start;

  logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data, w_act_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_pend_en, r_act_dp, r_act_en, w_act_dp, w_act_en;
  logic                    r_pend_blz, r_act_blz, w_act_blz;

  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_lead;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [3:0]            w_nib;
  logic                  w_en_bit, w_dp_bit, w_blank_bit;
  logic [6:0]            w_dec_seg;
  logic [NUM_DIGITS-1:0] w_an_hi;
  logic [6:0]            w_seg_hi;
  logic                  w_dp_hi;

  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_done;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Leaving IDLE also starts a frame so the first scan shows the pending data
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_nxt_cnt     = r_cnt;
    w_wrap        = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_tick) begin
          w_nxt_state   = ST_GUARD;
          w_nxt_idx     = 3'd0;
          w_nxt_cnt     = '0;
          w_frame_start = 1'b1;
        end
      end
      ST_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_nxt_state = ST_DRIVE;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (r_tick) begin
          w_nxt_state = ST_GUARD;
          w_nxt_cnt   = '0;
          if (r_idx == IDX_LAST) begin
            w_nxt_idx     = 3'd0;
            w_wrap        = 1'b1;
            w_frame_start = 1'b1;
          end else begin
            w_nxt_idx = r_idx + 3'd1;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // A load coinciding with the frame start bypasses the pending buffer
  always_comb begin
    w_act_data = r_act_data;
    w_act_dp   = r_act_dp;
    w_act_en   = r_act_en;
    w_act_blz  = r_act_blz;
    if (w_frame_start) begin
      if (load) begin
        w_act_data = digit_data;
        w_act_dp   = dp_in;
        w_act_en   = digit_en;
        w_act_blz  = blank_lz;
      end else begin
        w_act_data = r_pend_data;
        w_act_dp   = r_pend_dp;
        w_act_en   = r_pend_en;
        w_act_blz  = r_pend_blz;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_en   <= '0;
      r_pend_blz  <= 1'b0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_en    <= '0;
      r_act_blz   <= 1'b0;
    end else begin
      if (load) begin
        r_pend_data <= digit_data;
        r_pend_dp   <= dp_in;
        r_pend_en   <= digit_en;
        r_pend_blz  <= blank_lz;
      end
      r_act_data <= w_act_data;
      r_act_dp   <= w_act_dp;
      r_act_en   <= w_act_en;
      r_act_blz  <= w_act_blz;
    end
  end

  // Blank zeros from the top digit down; digit 0 always shows
  always_comb begin
    w_blank = '0;
    w_lead  = w_act_blz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_lead     = w_lead & (w_act_data[4*i +: 4] == 4'h0);
      w_blank[i] = w_lead;
    end
  end

  always_comb begin
    w_nib       = 4'h0;
    w_en_bit    = 1'b0;
    w_dp_bit    = 1'b0;
    w_blank_bit = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_nxt_idx == 3'(i)) begin
        w_nib       = w_act_data[4*i +: 4];
        w_en_bit    = w_act_en[i];
        w_dp_bit    = w_act_dp[i];
        w_blank_bit = w_blank[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .i_nibble (w_nib),
    .o_seg    (w_dec_seg)
  );

  // Outputs are computed from next-state values so they switch with the state
  always_comb begin
    w_an_hi  = '0;
    w_seg_hi = SEG_OFF;
    w_dp_hi  = 1'b0;
    if (w_nxt_state == ST_DRIVE) begin
      w_an_hi  = w_en_bit ? w_onehot : '0;
      w_seg_hi = w_blank_bit ? SEG_OFF : w_dec_seg;
      w_dp_hi  = w_dp_bit;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_an         <= {NUM_DIGITS{ACTIVE_LOW_AN}};
      r_seg        <= SEG_OFF ^ {7{ACTIVE_LOW_SEG}};
      r_dp         <= ACTIVE_LOW_SEG;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_hi ^ {NUM_DIGITS{ACTIVE_LOW_AN}};
      r_seg        <= w_seg_hi ^ {7{ACTIVE_LOW_SEG}};
      r_dp         <= w_dp_hi ^ ACTIVE_LOW_SEG;
      r_frame_done <= w_wrap;
    end
  end

  assign an_out     = r_an;
  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign scan_idx   = r_idx;
  assign frame_done = r_frame_done;

endmodule
